// File: rtl/dff_input_filter_if.sv
// Signal bundle between a raw asynchronous source and the input filter.
// The source side (master) drives the raw line; the filter (slave) returns
// the conditioned level, its edge pulses, pending status and glitch count.
`timescale 1ns/10ps
interface dff_input_filter_if #(
    parameter int CNT_W = 8
) ();
    logic             d;
    logic             q;
    logic             qbar;
    logic             rise;
    logic             fall;
    logic             busy;
    logic [CNT_W-1:0] glitch_cnt;

    modport master (
        output d,
        input  q, qbar, rise, fall, busy, glitch_cnt
    );

    modport slave (
        input  d,
        output q, qbar, rise, fall, busy, glitch_cnt
    );
endinterface

// File: rtl/dff_input_filter.sv
// Receive-side conditioner for a raw asynchronous single-bit line.
// The line is synchronised into clk, then debounced: q only moves after the
// synchronised input has held the opposite level for STABLE_CYCLES samples.
// Transitions that collapse before completing are counted in glitch_cnt.
`timescale 1ns/10ps
module dff_input_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input logic            clk,
    input logic            clear,
    dff_input_filter_if.slave bus
);

    // Elaboration-time guards on the parameter ranges.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("dff_input_filter: SYNC_STAGES must be in 2..4");
    end
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
        $error("dff_input_filter: STABLE_CYCLES must be in 2..255");
    end
    if (CNT_W < 1 || CNT_W > 32 || (64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_bad_cnt_w
        $error("dff_input_filter: 2**CNT_W must exceed STABLE_CYCLES");
    end

    typedef enum logic [1:0] {
        S_LO    = 2'd0,
        S_LO2HI = 2'd1,
        S_HI    = 2'd2,
        S_HI2LO = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   d_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] glitch_q, glitch_d;
    logic [CNT_W-1:0] glitch_inc;
    logic             q_q, q_d;
    logic             qbar_q, qbar_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    // Synchroniser chain: only its last stage is allowed to reach the FSM.
    // NOTE: clocked state always uses non-blocking assignment so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.d};
        end
    end

    assign d_s = sync_q[SYNC_STAGES-1];

    // An abort at the all-ones count leaves the counter where it is.
    assign glitch_inc = (&glitch_q) ? glitch_q : glitch_q + CNT_ONE;

    // Next-state logic: pending states count identical samples of the new
    // level and either commit (with a pulse) or fall back (counting a glitch).
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        glitch_d = glitch_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;

        case (state_q)
            S_LO: begin
                if (d_s) begin
                    state_d = S_LO2HI;
                    cnt_d   = CNT_ONE;
                end
            end
            S_LO2HI: begin
                if (!d_s) begin
                    state_d  = S_LO;
                    cnt_d    = '0;
                    glitch_d = glitch_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HI: begin
                if (!d_s) begin
                    state_d = S_HI2LO;
                    cnt_d   = CNT_ONE;
                end
            end
            S_HI2LO: begin
                if (d_s) begin
                    state_d  = S_HI;
                    cnt_d    = '0;
                    glitch_d = glitch_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LO;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LO;
                cnt_d   = '0;
            end
        endcase

        // q is high exactly in the two states that belong to the high level.
        q_d    = (state_d == S_HI) || (state_d == S_HI2LO);
        qbar_d = ~q_d;
        busy_d = (state_d == S_LO2HI) || (state_d == S_HI2LO);
    end

    // State and output registers; qbar has its own flop so it is never a
    // combinational function of anything downstream of d.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q  <= S_LO;
            cnt_q    <= '0;
            glitch_q <= '0;
            q_q      <= 1'b0;
            qbar_q   <= 1'b1;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
            q_q      <= q_d;
            qbar_q   <= qbar_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.q          = q_q;
    assign bus.qbar       = qbar_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.busy       = busy_q;
    assign bus.glitch_cnt = glitch_q;

endmodule
